// File: rtl/crotchet_seq_pkg.sv
// Shared types and constants for the crotchet sequencer.
// Optional skip support is enabled with CROTCHET_SEQ_SKIP_EN.
package crotchet_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE,
      DONE
   } seq_state_e;

   localparam int NUM_CROTCHETS        = 104;
   localparam int CROTCHETS_PER_PHRASE = 8;
   localparam int LAST_PHRASE          = 12;
   localparam int MIN_PERIOD           = 2;

   localparam int PERIOD_W   = 20;
   localparam int CROTCHET_W = 7;
   localparam int PHRASE_W   = 4;

   function automatic logic [PERIOD_W-1:0] clamp_period(
      input logic [PERIOD_W-1:0] p
   );
      if (p < PERIOD_W'(MIN_PERIOD))
         return PERIOD_W'(MIN_PERIOD);
      return p;
   endfunction

endpackage

// File: rtl/crotchet_sequencer_if.sv
// Control and status bundle between a transport controller and
// the crotchet sequencer.
interface crotchet_sequencer_if;
   import crotchet_seq_pkg::*;

   logic                  start;
   logic                  pause;
   logic                  stop;
   logic                  skip;
   logic                  loop;
   logic [PERIOD_W-1:0]   tempo_period;
   logic [CROTCHET_W-1:0] crotchet;
   logic                  crotchet_pulse;
   logic [PHRASE_W-1:0]   phrase;
   logic                  running;
   logic                  done;

   modport master (
      output start, pause, stop, skip, loop, tempo_period,
      input  crotchet, crotchet_pulse, phrase, running, done
   );

   modport slave (
      input  start, pause, stop, skip, loop, tempo_period,
      output crotchet, crotchet_pulse, phrase, running, done
   );

endinterface

// File: rtl/tempo_divider.sv
// Beat timer: latches and clamps the tempo period, counts each
// beat down to zero and flags the crotchet boundary.
module tempo_divider
   import crotchet_seq_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                load,
   input  logic                run,
   input  logic                active,
   input  logic                hold,
   input  logic [PERIOD_W-1:0] period_in,
   output logic                boundary
);

   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [PERIOD_W-1:0] period_c;

   always_comb begin
      period_c = clamp_period(period_in);
      period_d = period_q;
      cnt_d    = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         period_d = period_c;
         cnt_d    = period_c - PERIOD_W'(1);
      end else if (active && !hold && cnt_q != '0) begin
         cnt_d = cnt_q - PERIOD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         period_q <= PERIOD_W'(MIN_PERIOD);
         cnt_q    <= '0;
      end else begin
         period_q <= period_d;
         cnt_q    <= cnt_d;
      end
   end

   assign boundary = run && (cnt_q == '0);

endmodule

// File: rtl/crotchet_sequencer.sv
// Crotchet playback sequencer: 104 crotchets in 13 phrases of 8.
// Define CROTCHET_SEQ_SKIP_EN to enable the skip-to-next-phrase input.
module crotchet_sequencer
   import crotchet_seq_pkg::*;
(
   input logic                 clk,
   input logic                 rst_n,
   crotchet_sequencer_if.slave bus
);

   localparam logic [CROTCHET_W-1:0] LAST_CROTCHET =
      CROTCHET_W'(NUM_CROTCHETS - 1);

   seq_state_e            state_q, state_d;
   logic [CROTCHET_W-1:0] crot_q, crot_d;
   logic                  pulse_q, pulse_d;
   logic                  running_q, running_d;
   logic                  done_q, done_d;

   logic                  load;
   logic                  clr;
   logic                  boundary;
   logic                  adv;
   logic                  past_end;
   logic [CROTCHET_W-1:0] tgt;

   tempo_divider u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .load      (load),
      .run       (state_q == RUN),
      .active    (state_q == RUN || state_q == PAUSE),
      .hold      (bus.pause),
      .period_in (bus.tempo_period),
      .boundary  (boundary)
   );

   always_comb begin
      state_d  = state_q;
      crot_d   = crot_q;
      pulse_d  = 1'b0;
      load     = 1'b0;
      clr      = 1'b0;
      adv      = 1'b0;
      past_end = 1'b0;
      tgt      = crot_q + CROTCHET_W'(1);
      if (bus.stop) begin
         state_d = IDLE;
         crot_d  = '0;
         clr     = 1'b1;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  state_d = RUN;
                  crot_d  = '0;
                  pulse_d = 1'b1;
                  load    = 1'b1;
               end
            end
            RUN, PAUSE: begin
`ifdef CROTCHET_SEQ_SKIP_EN
               if (bus.skip) begin
                  adv      = 1'b1;
                  tgt      = {crot_q[6:3] + 4'd1, 3'b000};
                  past_end = (crot_q[6:3] == PHRASE_W'(LAST_PHRASE));
               end else
`endif
               if (boundary) begin
                  adv      = 1'b1;
                  past_end = (crot_q == LAST_CROTCHET);
               end else if (state_q == RUN && bus.pause) begin
                  state_d = PAUSE;
               end else if (state_q == PAUSE && !bus.pause) begin
                  state_d = RUN;
               end
            end
         endcase
         // Past the final crotchet either wrap to the top or finish.
         if (adv) begin
            if (past_end && !bus.loop) begin
               state_d = DONE;
               crot_d  = LAST_CROTCHET;
               clr     = 1'b1;
            end else begin
               crot_d  = past_end ? '0 : tgt;
               pulse_d = 1'b1;
               load    = 1'b1;
            end
         end
      end
      running_d = (state_d == RUN) || (state_d == PAUSE);
      done_d    = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         crot_q    <= '0;
         pulse_q   <= 1'b0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         crot_q    <= crot_d;
         pulse_q   <= pulse_d;
         running_q <= running_d;
         done_q    <= done_d;
      end
   end

   assign bus.crotchet       = crot_q;
   assign bus.crotchet_pulse = pulse_q;
   assign bus.phrase         = crot_q[6:3];
   assign bus.running        = running_q;
   assign bus.done           = done_q;

endmodule

// File: tb/tb_crotchet_sequencer.sv
// Self-checking bench for crotchet_sequencer: directed scenarios
// plus randomized traffic against a beat-level reference model.
module tb_crotchet_sequencer;
   import crotchet_seq_pkg::*;

`ifdef CROTCHET_SEQ_SKIP_EN
   localparam bit SKIP_EN = 1'b1;
`else
   localparam bit SKIP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   crotchet_sequencer_if bus ();

   crotchet_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference: playing/paused/finished flags, crotchet index, beat
   // length and cycles elapsed since the last crotchet pulse.
   bit m_play, m_paused, m_done, m_pulse;
   int m_crot, m_len, m_el;

   task automatic check(string tag, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  tag, act, exp, cyc);
      end
   endtask

   task automatic new_beat(int target, int tp);
      if (target >= NUM_CROTCHETS) begin
         if (bus.loop) begin
            m_crot = 0; m_pulse = 1; m_len = tp; m_el = 0;
         end else begin
            m_play = 0; m_paused = 0; m_done = 1;
            m_crot = NUM_CROTCHETS - 1;
         end
      end else begin
         m_crot = target; m_pulse = 1; m_len = tp; m_el = 0;
      end
   endtask

   task automatic model_step();
      int tp;
      tp = (bus.tempo_period < 2) ? 2 : int'(bus.tempo_period);
      m_pulse = 0;
      if (!rst_n) begin
         m_play = 0; m_paused = 0; m_done = 0;
         m_crot = 0; m_el = 0; m_len = 2;
      end else if (bus.stop) begin
         m_play = 0; m_paused = 0; m_done = 0; m_crot = 0;
      end else if (!m_play) begin
         if (bus.start) begin
            m_play = 1; m_paused = 0; m_done = 0;
            m_crot = 0; m_pulse = 1; m_len = tp; m_el = 0;
         end
      end else if (SKIP_EN && bus.skip) begin
         new_beat((m_crot / 8 + 1) * 8, tp);
      end else if (!m_paused && m_el == m_len - 1) begin
         new_beat(m_crot + 1, tp);
      end else if (!m_paused && bus.pause) begin
         m_paused = 1;
      end else if (!(m_paused && bus.pause)) begin
         m_paused = 0;
         m_el++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      check("crotchet", int'(bus.crotchet), m_crot);
      check("pulse", int'(bus.crotchet_pulse), int'(m_pulse));
      check("phrase", int'(bus.phrase), m_crot / 8);
      check("running", int'(bus.running), int'(m_play));
      check("done", int'(bus.done), int'(m_done));
   endtask

   task automatic go();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_pulse(input int max, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.crotchet_pulse && n < max);
      if (!bus.crotchet_pulse)
         check("pulse_timeout", 0, 1);
   endtask

   initial begin
      int t0, last, cnt, n, n2;
      bus.start = 0; bus.pause = 0; bus.stop = 0;
      bus.skip = 0; bus.loop = 0; bus.tempo_period = 20'd10;
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Full song at period 10, no loop.
      go();
      check("first_pulse", int'(bus.crotchet_pulse), 1);
      t0 = cyc; last = cyc; cnt = 0;
      while (!bus.done && cyc - t0 < 1200) begin
         tick();
         if (bus.crotchet_pulse) begin
            last = cyc;
            cnt++;
         end
      end
      check("done_reached", int'(bus.done), 1);
      check("pulse_count", cnt, 103);
      check("last_pulse_cyc", last - t0, 1030);
      check("done_delay", cyc - last, 10);
      check("done_crot", int'(bus.crotchet), 103);

      // Restart from DONE, then pause 25 cycles at count 4.
      go();
      check("restart_crot", int'(bus.crotchet), 0);
      check("restart_pulse", int'(bus.crotchet_pulse), 1);
      repeat (5) tick();
      bus.pause = 1'b1;
      repeat (25) tick();
      check("paused_running", int'(bus.running), 1);
      bus.pause = 1'b0;
      wait_pulse(100, n);
      check("pause_gap", 30 + n, 35);

      // Tempo change mid-beat, then clamp of period 0.
      repeat (3) tick();
      bus.tempo_period = 20'd3;
      wait_pulse(100, n);
      check("tempo_old_beat", 3 + n, 10);
      wait_pulse(100, n);
      check("tempo_new_beat", n, 3);
      bus.tempo_period = 20'd0;
      wait_pulse(100, n);
      check("tempo_latched", n, 3);
      wait_pulse(100, n);
      check("clamp_gap", n, 2);
      wait_pulse(100, n);
      check("clamp_gap2", n, 2);

      // Skip at crotchet 13, then stop+skip priority.
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      bus.tempo_period = 20'd10;
      go();
      n2 = 0;
      while (bus.crotchet != 7'd13 && n2 < 20) begin
         wait_pulse(20, n);
         n2++;
      end
      bus.skip = 1'b1;
      tick();
      bus.skip = 1'b0;
      check("skip_crot", int'(bus.crotchet), SKIP_EN ? 16 : 13);
      check("skip_phrase", int'(bus.phrase), SKIP_EN ? 2 : 1);
      check("skip_pulse", int'(bus.crotchet_pulse), SKIP_EN ? 1 : 0);
      tick();
      bus.stop = 1'b1;
      bus.skip = 1'b1;
      tick();
      bus.stop = 1'b0;
      bus.skip = 1'b0;
      check("prio_crot", int'(bus.crotchet), 0);
      check("prio_pulse", int'(bus.crotchet_pulse), 0);
      check("prio_running", int'(bus.running), 0);

      // Loop wrap at period 4.
      bus.tempo_period = 20'd4;
      bus.loop = 1'b1;
      go();
      n2 = 0;
      while (bus.crotchet != 7'd103 && n2 < 110) begin
         wait_pulse(10, n);
         n2++;
      end
      wait_pulse(10, n);
      check("wrap_gap", n, 4);
      check("wrap_crot", int'(bus.crotchet), 0);
      check("wrap_running", int'(bus.running), 1);

      // Reset in the middle of playback.
      repeat (6) tick();
      rst_n = 1'b0;
      tick();
      check("rst_crot", int'(bus.crotchet), 0);
      check("rst_pulse", int'(bus.crotchet_pulse), 0);
      check("rst_running", int'(bus.running), 0);
      check("rst_done", int'(bus.done), 0);
      rst_n = 1'b1;
      tick();
      check("post_rst_pulse", int'(bus.crotchet_pulse), 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         bus.start = ($urandom_range(0, 19) == 0);
         bus.stop  = ($urandom_range(0, 299) == 0);
         bus.skip  = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 14) == 0)
            bus.pause = ~bus.pause;
         if ($urandom_range(0, 99) == 0)
            bus.loop = ~bus.loop;
         if ($urandom_range(0, 39) == 0)
            bus.tempo_period = 20'($urandom_range(0, 6));
         rst_n = ($urandom_range(0, 699) != 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
